// File: rtl/config_pkg.sv
// Shared configuration for the ULX3S button conditioner: repeat-FSM states
// and default timing constants derived from the board clock.
package config_pkg;

  localparam int ClkFreqHz = 25_000_000;

  // 10 ms debounce, 0.5 s until the first repeat, then 10 repeats per second.
  localparam int BtnDebounceCycles     = ClkFreqHz / 100;
  localparam int BtnRepeatDelayCycles  = ClkFreqHz / 2;
  localparam int BtnRepeatPeriodCycles = ClkFreqHz / 10;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDelay  = 2'd1,
    StRepeat = 2'd2
  } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce counter, autorepeat FSM and
// registered press/release pulses.
module btn_channel
  import config_pkg::*;
#(
  parameter int SyncStages         = 2,
  parameter int DebounceCycles     = BtnDebounceCycles,
  parameter int RepeatDelayCycles  = BtnRepeatDelayCycles,
  parameter int RepeatPeriodCycles = BtnRepeatPeriodCycles
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int DbCntW       = $clog2(DebounceCycles + 1);
  localparam int RptMaxCycles = (RepeatDelayCycles > RepeatPeriodCycles) ?
                                RepeatDelayCycles : RepeatPeriodCycles;
  localparam int RptCntW      = $clog2(RptMaxCycles + 1);

  localparam logic [DbCntW-1:0]  DbLast     = DbCntW'(DebounceCycles - 1);
  localparam logic [DbCntW-1:0]  DbMax      = '1;
  localparam logic [RptCntW-1:0] DelayLast  = RptCntW'(RepeatDelayCycles - 1);
  localparam logic [RptCntW-1:0] PeriodLast = RptCntW'(RepeatPeriodCycles - 1);
  localparam logic [RptCntW-1:0] RptMax     = '1;

  logic [SyncStages-1:0] r_sync;
  logic [DbCntW-1:0]     r_dbCnt;
  logic                  r_level;
  logic                  r_press;
  logic                  r_release;
  btn_state_e            r_state;
  btn_state_e            w_stateNext;
  logic [RptCntW-1:0]    r_rptCnt;
  logic [RptCntW-1:0]    w_rptCntNext;
  logic                  w_rptPulse;
  logic                  w_synced;
  logic                  w_mismatch;
  logic                  w_accept;
  logic                  w_rise;
  logic                  w_fall;

  assign w_synced   = r_sync[SyncStages-1];
  assign w_mismatch = w_synced ^ r_level;
  assign w_accept   = w_mismatch && (r_dbCnt == DbLast);
  assign w_rise     = w_accept & ~r_level;
  assign w_fall     = w_accept & r_level;

  // Shift the raw pin through the metastability chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SyncStages-2:0], i_btn};
  end

  // Count consecutive disagreeing cycles and flip the level once stable long enough.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dbCnt <= '0;
      r_level <= 1'b0;
    end else begin
      r_level <= r_level ^ w_accept;
      if (!w_mismatch || w_accept) r_dbCnt <= '0;
      else if (r_dbCnt != DbMax)   r_dbCnt <= r_dbCnt + 1'b1;
    end
  end

  // Repeat FSM state and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_rptCnt <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_rptCnt <= w_rptCntNext;
    end
  end

  // Repeat FSM next state; a falling level or disabled repeat aborts without a pulse.
  always_comb begin
    w_stateNext  = r_state;
    w_rptCntNext = r_rptCnt;
    w_rptPulse   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_rise && i_repeat_en) begin
          w_stateNext  = StDelay;
          w_rptCntNext = '0;
        end
      end
      StDelay: begin
        if (r_rptCnt == DelayLast) begin
          w_rptPulse   = 1'b1;
          w_stateNext  = StRepeat;
          w_rptCntNext = '0;
        end else if (r_rptCnt != RptMax) begin
          w_rptCntNext = r_rptCnt + 1'b1;
        end
      end
      StRepeat: begin
        if (r_rptCnt == PeriodLast) begin
          w_rptPulse   = 1'b1;
          w_rptCntNext = '0;
        end else if (r_rptCnt != RptMax) begin
          w_rptCntNext = r_rptCnt + 1'b1;
        end
      end
      default: begin
        w_stateNext  = StIdle;
        w_rptCntNext = '0;
      end
    endcase
    if ((r_state != StIdle) && (!i_repeat_en || w_fall)) begin
      w_stateNext  = StIdle;
      w_rptCntNext = '0;
      w_rptPulse   = 1'b0;
    end
  end

  // Register the press/release pulses so they line up with the level change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_rise | w_rptPulse;
      r_release <= w_fall;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/ulx3s_input_conditioner.sv
// ULX3S push-button conditioner: polarity fix-up and one btn_channel per pin.
module ulx3s_input_conditioner
  import config_pkg::*;
#(
  parameter int                    NumChannels        = 4,
  parameter int                    SyncStages         = 2,
  parameter int                    DebounceCycles     = BtnDebounceCycles,
  parameter int                    RepeatDelayCycles  = BtnRepeatDelayCycles,
  parameter int                    RepeatPeriodCycles = BtnRepeatPeriodCycles,
  parameter logic [NumChannels-1:0] InvertMask        = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] btn_i,
  input  logic [NumChannels-1:0] repeat_en_i,
  output logic [NumChannels-1:0] level_o,
  output logic [NumChannels-1:0] press_o,
  output logic [NumChannels-1:0] release_o
);

  if (NumChannels < 1)        $error("NumChannels must be at least 1");
  if (SyncStages < 2)         $error("SyncStages must be at least 2");
  if (DebounceCycles < 1)     $error("DebounceCycles must be at least 1");
  if (RepeatDelayCycles < 1)  $error("RepeatDelayCycles must be at least 1");
  if (RepeatPeriodCycles < 1) $error("RepeatPeriodCycles must be at least 1");

  logic [NumChannels-1:0] w_btnActive;

  assign w_btnActive = btn_i ^ InvertMask;

  for (genvar g = 0; g < NumChannels; g++) begin : gen_channel
    btn_channel #(
      .SyncStages        (SyncStages),
      .DebounceCycles    (DebounceCycles),
      .RepeatDelayCycles (RepeatDelayCycles),
      .RepeatPeriodCycles(RepeatPeriodCycles)
    ) u_channel (
      .i_clk      (clk_i),
      .i_rst_n    (rst_ni),
      .i_btn      (w_btnActive[g]),
      .i_repeat_en(repeat_en_i[g]),
      .o_level    (level_o[g]),
      .o_press    (press_o[g]),
      .o_release  (release_o[g])
    );
  end

endmodule
